// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
//
// Set-associative branch target buffer for the fetch stage.
//   - Combinational, zero-latency lookup on the fetch PC.
//   - Trained at resolve time from EX. Training uses saturating counters, target
//     replacement, and round-robin allocation within a set.
//   - A sequential flush engine invalidates one set per cycle. It is started by
//     flush_req or by reset.
//   - Optional return address stack, enabled with the macro BTB_RAS_EN.
//
// Index/tag split: IDX = log2(SETS), set = pc[IDX+1:2], tag = pc[31:IDX+2].
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   lookup_pc    fetch PC to predict
//   pred_hit     valid tag match in exactly one way
//   pred_taken   predict a redirect
//   pred_target  predicted next PC (lookup_pc+4 when not taken)
//   upd_valid    resolved control-flow instruction from EX
//   upd_pc       PC of the resolved instruction
//   upd_taken    actual outcome
//   upd_target   actual target when taken
//   upd_kind     00 cond branch, 01 jump, 10 call, 11 return
//   flush_req    invalidate all entries (single-cycle pulse)
//   busy         flush in progress; lookups miss and updates are dropped
//
// Configuration macro
//   BTB_RAS_EN   adds a RAS_DEPTH x 32 circular return address stack.
//                The stack is trained at resolve time. Hits on return
//                entries take their target from the top of the stack.
// -----------------------------------------------------------------------------
module btb_predictor #(
  parameter int ENTRIES   = 64,
  parameter int WAYS      = 2,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_kind,
  input  logic        flush_req,
  output logic        busy
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [IDX-1:0]      LAST_SET = IDX'(SETS - 1);
  localparam logic [WAY_W-1:0]    LAST_WAY = WAY_W'(WAYS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef enum logic [1:0] {
    KIND_COND = 2'b00,
    KIND_JUMP = 2'b01,
    KIND_CALL = 2'b10,
    KIND_RET  = 2'b11
  } kind_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [31:0]         target;
    logic [1:0]          kind;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  // NOTE: only valid_q and rr_q carry meaning after a flush, so only they are
  // cleared. The payload array is never reset; a stale payload is harmless
  // behind a cleared valid bit.
  logic             valid_q [SETS][WAYS];
  entry_t           ent_q   [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];

  state_e           state_q;
  logic [IDX-1:0]   fidx_q;

  // Return-stack view used by the lookup path. It is tied off when the RAS
  // is not built.
  logic [31:0] ras_top;
  logic        ras_use;

  // ---------------------------------------------------------------------------
  // Lookup (combinational)
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   l_set;
  logic [TAG_W-1:0] l_tag;
  logic [2:0]       l_cnt;
  logic [WAY_W-1:0] l_way;
  logic             l_hit;
  logic [1:0]       l_kind;
  logic             l_ctr_msb;
  logic [31:0]      l_target;

  // NOTE: always_comb uses blocking assignments. Every variable gets a default
  // before the loop, so no latch is inferred and the match count accumulates
  // in order.
  always_comb begin
    l_set = lookup_pc[IDX+1:2];
    l_tag = lookup_pc[31:IDX+2];
    l_cnt = '0;
    l_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[l_set][w] && ent_q[l_set][w].tag == l_tag) begin
        l_cnt = l_cnt + 3'd1;
        l_way = WAY_W'(w);
      end
    end
    // A multi-way match is treated as a miss rather than trusting either way.
    l_hit     = (l_cnt == 3'd1);
    l_kind    = ent_q[l_set][l_way].kind;
    l_ctr_msb = ent_q[l_set][l_way].ctr[CTR_BITS-1];
    l_target  = ent_q[l_set][l_way].target;
  end

  assign busy        = rst || (state_q == S_FLUSH);
  assign pred_hit    = l_hit && !busy && (lookup_pc[1:0] == 2'b00);
  assign pred_taken  = pred_hit && ((l_kind != KIND_COND) || l_ctr_msb);
  assign pred_target = !pred_taken ? (lookup_pc + 32'd4)
                     : (ras_use ? ras_top : l_target);

  // ---------------------------------------------------------------------------
  // Update-side set match and victim choice
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   u_set;
  logic [TAG_W-1:0] u_tag;
  logic [2:0]       u_cnt;
  logic [WAY_W-1:0] u_way;
  logic             u_hit;
  logic             u_free;
  logic [WAY_W-1:0] u_victim;
  logic             upd_ok;

  always_comb begin
    u_set    = upd_pc[IDX+1:2];
    u_tag    = upd_pc[31:IDX+2];
    u_cnt    = '0;
    u_way    = '0;
    u_free   = 1'b0;
    u_victim = rr_q[u_set];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[u_set][w] && ent_q[u_set][w].tag == u_tag) begin
        u_cnt = u_cnt + 3'd1;
        u_way = WAY_W'(w);
      end
    end
    // Scan downwards so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[u_set][w]) begin
        u_free   = 1'b1;
        u_victim = WAY_W'(w);
      end
    end
    u_hit = (u_cnt == 3'd1);
  end

  // A flush request in the same cycle always beats a training update.
  assign upd_ok = upd_valid && !busy && !flush_req;

  // ---------------------------------------------------------------------------
  // Flush engine, valid bits and round-robin pointers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample pre-edge values, which is what gives a same-cycle lookup the
  // pre-update contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FLUSH;
      fidx_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            state_q <= S_FLUSH;
            fidx_q  <= '0;
          end else if (upd_ok && !u_hit && upd_taken) begin
            valid_q[u_set][u_victim] <= 1'b1;
            // The pointer only advances when it actually chose the victim.
            if (!u_free) begin
              rr_q[u_set] <= (rr_q[u_set] == LAST_WAY) ? '0 : rr_q[u_set] + WAY_W'(1);
            end
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[fidx_q][w] <= 1'b0;
          end
          rr_q[fidx_q] <= '0;
          if (flush_req) begin
            fidx_q <= '0;
          end else if (fidx_q == LAST_SET) begin
            state_q <= S_IDLE;
          end else begin
            fidx_q <= fidx_q + IDX'(1);
          end
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload training
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (upd_ok) begin
      if (u_hit) begin
        if (upd_taken) begin
          ent_q[u_set][u_way].kind <= upd_kind;
          if (ent_q[u_set][u_way].target != upd_target) begin
            ent_q[u_set][u_way].target <= upd_target;
            ent_q[u_set][u_way].ctr    <= CTR_WEAK;
          end else if (ent_q[u_set][u_way].ctr != CTR_MAX) begin
            ent_q[u_set][u_way].ctr <= ent_q[u_set][u_way].ctr + CTR_BITS'(1);
          end
        end else if (ent_q[u_set][u_way].ctr != '0) begin
          ent_q[u_set][u_way].ctr <= ent_q[u_set][u_way].ctr - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        ent_q[u_set][u_victim] <= '{tag: u_tag, target: upd_target, kind: upd_kind, ctr: CTR_WEAK};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return address stack
  // ---------------------------------------------------------------------------
`ifdef BTB_RAS_EN
  localparam int               RAS_W    = $clog2(RAS_DEPTH);
  localparam logic [RAS_W:0]   RAS_FULL = (RAS_W + 1)'(RAS_DEPTH);

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [RAS_W-1:0] sp_q;   // next free slot; top of stack is sp_q-1
  logic [RAS_W:0]   cnt_q;
  logic             ras_push;
  logic             ras_pop;

  assign ras_push = upd_ok && (upd_kind == KIND_CALL);
  assign ras_pop  = upd_ok && (upd_kind == KIND_RET) && (cnt_q != '0);
  assign ras_top  = ras_q[sp_q - RAS_W'(1)];
  assign ras_use  = (l_kind == KIND_RET) && (cnt_q != '0);

  // A push onto a full stack lands on the oldest slot, so the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (ras_push) begin
      sp_q <= sp_q + RAS_W'(1);
      if (cnt_q != RAS_FULL) begin
        cnt_q <= cnt_q + (RAS_W + 1)'(1);
      end
    end else if (ras_pop) begin
      sp_q  <= sp_q - RAS_W'(1);
      cnt_q <= cnt_q - (RAS_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_q[sp_q] <= upd_pc + 32'd4;
    end
  end
`else
  assign ras_top = '0;
  assign ras_use = 1'b0;

  // The low PC bits and RAS_DEPTH only matter when the stack is built.
  logic unused_cfg;
  assign unused_cfg = ^{upd_pc[1:0], RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_predictor
//
// Bench for btb_predictor with default parameters. Every cycle, the outputs
// are compared against a behavioural model. The model holds entries per set in
// plain arrays, tracks the flush as a countdown, and keeps the RAS as a queue.
// Directed scenarios pin the headline behaviours to fixed constants. A
// randomised phase follows, mixing updates, lookups, flushes and resets.
// -----------------------------------------------------------------------------
module tb_btb_predictor;

  localparam int ENTRIES   = 64;
  localparam int WAYS      = 2;
  localparam int CTR_BITS  = 2;
  localparam int RAS_DEPTH = 8;
  localparam int SETS      = ENTRIES / WAYS;
  localparam int IDX       = $clog2(SETS);
  localparam int WEAK      = 1 << (CTR_BITS - 1);
  localparam int CMAX      = (1 << CTR_BITS) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_kind;
  logic        flush_req;
  logic        busy;

  always #5 clk = ~clk;

  btb_predictor #(
    .ENTRIES  (ENTRIES),
    .WAYS     (WAYS),
    .CTR_BITS (CTR_BITS),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (lookup_pc),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_kind   (upd_kind),
    .flush_req  (flush_req),
    .busy       (busy)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          valid;
    int unsigned tag;
    bit [31:0]   target;
    bit [1:0]    kind;
    int          ctr;
  } ment_t;

  ment_t     mdl [SETS][WAYS];
  int        mrr [SETS];
  bit [31:0] mras [$];
  int        busy_left;

  int n_tests;
  int n_fail;
  bit busy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int set_of(input bit [31:0] pc);
    return int'((pc >> 2) & 32'(SETS - 1));
  endfunction

  function automatic int unsigned tag_of(input bit [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic int m_find(input bit [31:0] pc);
    int s;
    s = set_of(pc);
    for (int w = 0; w < WAYS; w++) begin
      if (mdl[s][w].valid && mdl[s][w].tag == tag_of(pc)) return w;
    end
    return -1;
  endfunction

  function automatic void m_invalidate();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mdl[s][w].valid = 1'b0;
    end
  endfunction

  function automatic void m_predict(input bit [31:0] pc, input bit r,
                                    output bit b, output bit h, output bit t,
                                    output bit [31:0] tg);
    int s;
    int w;
    b  = r || (busy_left > 0);
    h  = 1'b0;
    t  = 1'b0;
    tg = pc + 32'd4;
    if (b || pc[1:0] != 2'b00) return;
    s = set_of(pc);
    w = m_find(pc);
    if (w < 0) return;
    h = 1'b1;
    t = (mdl[s][w].kind != 2'b00) || (mdl[s][w].ctr >= WEAK);
    if (t) begin
      tg = mdl[s][w].target;
`ifdef BTB_RAS_EN
      if (mdl[s][w].kind == 2'b11 && mras.size() > 0) tg = mras[$];
`endif
    end
  endfunction

  function automatic void m_apply(input bit [31:0] pc, input bit tk,
                                  input bit [31:0] tgt, input bit [1:0] k);
    int s;
    int w;
    int v;
    s = set_of(pc);
    w = m_find(pc);
    if (w >= 0) begin
      if (tk) begin
        if (mdl[s][w].target != tgt) begin
          mdl[s][w].target = tgt;
          mdl[s][w].ctr    = WEAK;
        end else if (mdl[s][w].ctr < CMAX) begin
          mdl[s][w].ctr++;
        end
        mdl[s][w].kind = k;
      end else if (mdl[s][w].ctr > 0) begin
        mdl[s][w].ctr--;
      end
    end else if (tk) begin
      v = -1;
      for (int i = 0; i < WAYS; i++) if (!mdl[s][i].valid && v < 0) v = i;
      if (v < 0) begin
        v      = mrr[s];
        mrr[s] = (mrr[s] + 1) % WAYS;
      end
      mdl[s][v] = '{1'b1, tag_of(pc), tgt, k, WEAK};
    end
`ifdef BTB_RAS_EN
    if (k == 2'b10) begin
      mras.push_back(pc + 32'd4);
      if (mras.size() > RAS_DEPTH) void'(mras.pop_front());
    end else if (k == 2'b11 && mras.size() > 0) begin
      void'(mras.pop_back());
    end
`endif
  endfunction

  // Advance the model by one clock edge, using the inputs the DUT sampled.
  function automatic void m_edge();
    if (rst) begin
      busy_left = SETS;
      m_invalidate();
      mras.delete();
    end else if (flush_req) begin
      busy_left = SETS;
      m_invalidate();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (upd_valid) begin
      m_apply(upd_pc, upd_taken, upd_target, upd_kind);
    end
  endfunction

  // Compare all outputs on the falling edge, then step the model on the
  // rising edge. Inputs change 1 time unit after the rising edge.
  task automatic cycle();
    bit        eb;
    bit        eh;
    bit        et;
    bit [31:0] etg;
    @(negedge clk);
    m_predict(lookup_pc, rst, eb, eh, et, etg);
    busy_seen = busy;
    check("busy",        32'(busy),       32'(eb));
    check("pred_hit",    32'(pred_hit),   32'(eh));
    check("pred_taken",  32'(pred_taken), 32'(et));
    check("pred_target", pred_target,     etg);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic do_upd(input bit [31:0] pc, input bit tk, input bit [31:0] tg, input bit [1:0] k);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tg;
    upd_kind   = k;
    cycle();
    upd_valid  = 1'b0;
  endtask

  task automatic probe(input string tag, input bit [31:0] pc, input bit eh, input bit et,
                       input bit [31:0] etg);
    lookup_pc = pc;
    #2;
    check({tag, "_hit"},    32'(pred_hit),   32'(eh));
    check({tag, "_taken"},  32'(pred_taken), 32'(et));
    check({tag, "_target"}, pred_target,     etg);
    cycle();
  endtask

  task automatic count_busy(input string tag, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < SETS + 8; i++) begin
      cycle();
      if (busy_seen) n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  function automatic bit [31:0] rand_pc();
    bit [31:0] pc;
    pc = (32'($urandom_range(0, 7)) << 7) | (32'($urandom_range(0, 3)) << 2);
    if ($urandom_range(0, 1) == 1) pc = pc | 32'h8000_0000;
    return pc;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r;
    n_tests    = 0;
    n_fail     = 0;
    busy_left  = 0;
    busy_seen  = 1'b0;
    m_invalidate();
    rst        = 1'b1;
    lookup_pc  = '0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    upd_kind   = 2'b00;
    flush_req  = 1'b0;

    // Reset for one cycle, then SETS busy cycles.
    cycle();
    rst       = 1'b0;
    lookup_pc = 32'h8000_0010;
    count_busy("rst_busy_cycles", SETS);
    probe("reset_lookup", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);

    // Train a conditional branch, then detrain it.
    do_upd(32'h100, 1'b1, 32'h200, 2'b00);
    probe("train", 32'h100, 1'b1, 1'b1, 32'h200);
    do_upd(32'h100, 1'b0, 32'h0, 2'b00);
    do_upd(32'h100, 1'b0, 32'h0, 2'b00);
    probe("untrain", 32'h100, 1'b1, 1'b0, 32'h104);

    // Saturate to 3, then retarget: the counter drops to weak-taken.
    repeat (3) do_upd(32'h100, 1'b1, 32'h200, 2'b00);
    probe("saturated", 32'h100, 1'b1, 1'b1, 32'h200);
    do_upd(32'h100, 1'b1, 32'h300, 2'b00);
    probe("retarget", 32'h100, 1'b1, 1'b1, 32'h300);
    do_upd(32'h100, 1'b0, 32'h0, 2'b00);
    probe("retarget_weak", 32'h100, 1'b1, 1'b0, 32'h104);

    // A flush colliding with an update: the flush wins.
    upd_valid  = 1'b1;
    upd_pc     = 32'h1004;
    upd_taken  = 1'b1;
    upd_target = 32'h5000;
    upd_kind   = 2'b01;
    flush_req  = 1'b1;
    cycle();
    upd_valid  = 1'b0;
    flush_req  = 1'b0;
    count_busy("flush_busy_cycles", SETS);
    probe("flush_miss", 32'h100, 1'b0, 1'b0, 32'h104);
    probe("flush_dropped", 32'h1004, 1'b0, 1'b0, 32'h1008);

    // Three-way conflict in set 0, then round-robin eviction.
    do_upd(32'h000, 1'b1, 32'hA00, 2'b01);
    do_upd(32'h100, 1'b1, 32'hB00, 2'b01);
    do_upd(32'h200, 1'b1, 32'hC00, 2'b01);
    probe("conflict_000", 32'h000, 1'b0, 1'b0, 32'h004);
    probe("conflict_100", 32'h100, 1'b1, 1'b1, 32'hB00);
    probe("conflict_200", 32'h200, 1'b1, 1'b1, 32'hC00);
    do_upd(32'h300, 1'b1, 32'hD00, 2'b01);
    probe("rr_evict_100", 32'h100, 1'b0, 1'b0, 32'h104);
    probe("rr_keep_200", 32'h200, 1'b1, 1'b1, 32'hC00);

    // Misaligned lookups never hit; the fall-through address wraps.
    probe("misaligned", 32'h202, 1'b0, 1'b0, 32'h206);
    probe("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

`ifdef BTB_RAS_EN
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    count_busy("ras_flush_busy", SETS);
    // After these updates the stack is [0x404, 0x504] and 0x900 is a return entry.
    do_upd(32'h400, 1'b1, 32'h2000, 2'b10);
    do_upd(32'h500, 1'b1, 32'h3000, 2'b10);
    do_upd(32'h900, 1'b1, 32'h1234, 2'b11);
    do_upd(32'h500, 1'b1, 32'h3000, 2'b10);
    probe("ras_top1", 32'h900, 1'b1, 1'b1, 32'h504);
    do_upd(32'h900, 1'b1, 32'h1234, 2'b11);
    probe("ras_top2", 32'h900, 1'b1, 1'b1, 32'h404);
    do_upd(32'h900, 1'b1, 32'h1234, 2'b11);
    probe("ras_empty", 32'h900, 1'b1, 1'b1, 32'h1234);
    // Nine pushes into an eight-deep stack: the first push is lost.
    for (int i = 0; i < 9; i++) do_upd(32'h1004 + 32'(i) * 32'h80, 1'b1, 32'h6000, 2'b10);
    probe("ras_full_top", 32'h900, 1'b1, 1'b1, 32'h1004 + 32'd8 * 32'h80 + 32'd4);
    repeat (7) do_upd(32'h900, 1'b1, 32'h1234, 2'b11);
    probe("ras_second_oldest", 32'h900, 1'b1, 1'b1, 32'h1004 + 32'h80 + 32'd4);
    do_upd(32'h900, 1'b1, 32'h1234, 2'b11);
    probe("ras_oldest_lost", 32'h900, 1'b1, 1'b1, 32'h1234);
`endif

    // Randomised mix, checked every cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      r          = int'($urandom_range(0, 999));
      rst        = (r < 2);
      flush_req  = (r >= 2 && r < 6);
      upd_valid  = ($urandom_range(0, 2) != 0);
      upd_pc     = rand_pc();
      upd_taken  = ($urandom_range(0, 3) != 0);
      upd_target = 32'h7000 + 32'($urandom_range(0, 3)) * 32'h40;
      upd_kind   = 2'($urandom_range(0, 3));
      lookup_pc  = rand_pc();
      if ($urandom_range(0, 9) == 0) lookup_pc = lookup_pc | 32'($urandom_range(1, 3));
      cycle();
    end
    rst       = 1'b0;
    flush_req = 1'b0;
    upd_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
